// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: WIDTH+1 stall cycles from issue, then results held in DONE.
// Latency: start at cycle 0, done at cycle WIDTH+1; DONE is extended by hold, and annul aborts from any state.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  input  logic             hold,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a;
  logic             r_qsign, r_rsign, r_zero;

  logic             w_accept, w_step, w_last, w_ge;
  logic [WIDTH:0]   w_part;
  logic [WIDTH-1:0] w_diff, w_rem_step, w_quo_step;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_fix, w_r_fix;

  // -MIN wraps back to MIN, which is the correct magnitude when read unsigned.
  assign w_abs_a = (signed_div & a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (signed_div & b[WIDTH-1]) ? -b : b;

  assign w_accept = (r_state == S_IDLE) & start & ~annul;
  assign w_step   = (r_state == S_BUSY) & ~annul;
  assign w_last   = (r_cnt == LAST);

  // Dividend register doubles as the quotient shift register.
  assign w_part     = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_part >= {1'b0, r_div});
  assign w_diff     = w_part[WIDTH-1:0] - r_div;
  assign w_rem_step = w_ge ? w_diff : w_part[WIDTH-1:0];
  assign w_quo_step = {r_dvd[WIDTH-2:0], w_ge};

  assign w_q_fix = r_zero  ? {WIDTH{1'b1}} :
                   r_qsign ? -w_quo_step : w_quo_step;
  assign w_r_fix = r_zero  ? r_a :
                   r_rsign ? -w_rem_step : w_rem_step;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (annul) w_next = S_IDLE;
               else if (w_last) w_next = S_DONE;
      S_DONE:  if (annul || !hold) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_a       <= '0;
      r_qsign   <= 1'b0;
      r_rsign   <= 1'b0;
      r_zero    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_dvd   <= w_abs_a;
      r_rem   <= '0;
      r_div   <= w_abs_b;
      r_a     <= a;
      r_qsign <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
      r_rsign <= a[WIDTH-1] & signed_div;
      r_zero  <= (b == '0);
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
      r_dvd <= w_quo_step;
      r_rem <= w_rem_step;
      if (w_last) begin
        quotient  <= w_q_fix;
        remainder <= w_r_fix;
      end
    end
  end

  // An annulled instruction must not write LO/HI even if it already reached DONE.
  assign done  = (r_state == S_DONE) & ~annul;
  assign stall = (((r_state == S_IDLE) & start) | (r_state == S_BUSY)) & ~annul;

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq against a plain-arithmetic reference model.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn, start, signed_div, annul, hold;
  logic [W-1:0] a, b;
  logic         stall, done;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  div_seq #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .hold(hold),
    .stall(stall), .done(done), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sx, sy;
    if (y == '0) begin
      q = '1;
      r = x;
    end else if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = W'(sx / sy);
      r  = W'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Issue one divide and check stall window, done timing, results, and optional hold extension.
  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic sg,
                         input int nhold, input bit idle_after, input string tag);
    logic [W-1:0] eq, er;
    int busy_ok;
    ref_div(ta, tb, sg, eq, er);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; signed_div = sg; hold = 1'b0; annul = 1'b0;
    #1;
    chk({tag, "_c0_stall"}, 64'(stall), 64'd1);
    busy_ok = 0;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; signed_div = ~sg;
      #1;
      if (stall === 1'b1 && done === 1'b0) busy_ok++;
    end
    chk({tag, "_busy_cycles"}, 64'(busy_ok), 64'(W));
    for (int k = 0; k <= nhold; k++) begin
      @(negedge clk);
      hold  = (k < nhold);
      start = (k < nhold);
      #1;
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_done_stall"}, 64'(stall), 64'd0);
      chk({tag, "_q"}, 64'(quotient), 64'(eq));
      chk({tag, "_r"}, 64'(remainder), 64'(er));
    end
    hold = 1'b0;
    start = 1'b0;
    last_q = eq;
    last_r = er;
    if (idle_after) begin
      @(negedge clk);
      #1;
      chk({tag, "_idle_done"}, 64'(done), 64'd0);
      chk({tag, "_idle_stall"}, 64'(stall), 64'd0);
    end
  endtask

  initial begin
    int seen_done;
    logic [W-1:0] ra, rb;
    logic rs;

    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; hold = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 0, 1'b1, "u100_7");
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, 1'b1, "s_m7_2");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b1, "s_min_m1");
    run_div(32'h12345678, 32'd0, 1'b1, 0, 1'b1, "s_div0");
    run_div(32'h12345678, 32'd0, 1'b0, 0, 1'b1, "u_div0");
    run_div(32'h80000000, 32'd0, 1'b1, 0, 1'b1, "s_min_div0");

    // Annul in the middle of the iterations.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    annul = 1'b1;
    #1;
    chk("annul_stall", 64'(stall), 64'd0);
    chk("annul_done", 64'(done), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul_idle_stall", 64'(stall), 64'd0);
    chk("annul_keep_q", 64'(quotient), 64'(last_q));
    chk("annul_keep_r", 64'(remainder), 64'(last_r));
    seen_done = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || stall !== 1'b0) seen_done++;
    end
    chk("annul_no_done", 64'(seen_done), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 0, 1'b1, "after_annul");

    // Annul beats start in IDLE.
    @(negedge clk);
    start = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5;
    #1;
    chk("prio_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1;
    chk("prio_not_busy", 64'(stall), 64'd0);

    run_div(32'hDEADBEEF, 32'h00001234, 1'b1, 3, 1'b1, "hold3");

    run_div(32'd77, 32'd8, 1'b0, 0, 1'b0, "b2b_1");
    run_div(32'hFFFFFF00, 32'hFFFFFFF0, 1'b1, 0, 1'b1, "b2b_2");

    // Reset asserted mid-operation.
    @(negedge clk);
    start = 1'b1; a = 32'd123456; b = 32'd789; signed_div = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    chk("midrst_q", 64'(quotient), 64'd0);
    chk("midrst_r", 64'(remainder), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("midrst_idle_stall", 64'(stall), 64'd0);
    run_div(32'd123456, 32'd789, 1'b0, 0, 1'b1, "after_rst");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, 0, 1'($urandom_range(0, 1)), "rand");
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
